// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: address/pointer width derivation and
// parameter range checks, kept here so sync and future async variants agree.
package fifo_pkg;

    // Ceiling log2 for elaboration-time width calculations (clog2(1) == 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Pointers carry one extra wrap bit above the array index.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    // True when depth is a power of two and at least two entries.
    function automatic bit depth_ok(input int depth);
        return (depth >= 2) && ((1 << clog2(depth)) == depth);
    endfunction

    // Full legality check for a FIFO parameter set.
    function automatic bit params_ok(input int data_w, input int depth,
                                     input int af_level, input int ae_level);
        return (data_w >= 1) && depth_ok(depth) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Write port: store one word per accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    // Read port is combinational so the head word falls through to the output.
    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/sync_fifo_p.sv
// Parametrised first-word-fall-through synchronous FIFO with occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
// All outputs decode from registered state only; inputs never reach outputs
// combinationally.
module sync_fifo_p
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        io_din,
    input  logic                     io_push,
    input  logic                     io_pop,
    input  logic                     io_flush,
    output logic [DATA_W-1:0]        io_dout,
    output logic                     io_empty,
    output logic                     io_full,
    output logic [clog2(DEPTH):0]    io_count,
    output logic                     io_almost_full,
    output logic                     io_almost_empty,
    output logic                     io_overflow,
    output logic                     io_underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

    // Refuse to elaborate an illegal parameter set.
    generate
        if (!params_ok(DATA_W, DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
            $error("sync_fifo_p: illegal DATA_W/DEPTH/AF_LEVEL/AE_LEVEL combination");
        end
    endgenerate

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;

    logic          empty;
    logic          full;
    logic          pop_acc;
    logic          push_acc;
    logic          mem_we;
    logic [PW-1:0] count;

    // Status decode from the registered pointers: equal pointers mean empty,
    // same index with opposite wrap bits means full.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign count = wr_ptr_reg - rd_ptr_reg;

    // A pop frees a slot this cycle, so a push into a full FIFO is accepted
    // alongside it. A push does not rescue a pop on an empty FIFO (no bypass).
    assign pop_acc  = io_pop && !empty;
    assign push_acc = io_push && (!full || pop_acc);

    // Flush suppresses the write so ignored pushes leave memory untouched.
    assign mem_we = push_acc && !io_flush;

    // Next-state logic for pointers and sticky error flags; flush wins.
    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (io_flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else begin
            if (pop_acc) begin
                rd_ptr_next = rd_ptr_reg + PW'(1);
            end
            if (push_acc) begin
                wr_ptr_next = wr_ptr_reg + PW'(1);
            end
            if (io_push && !push_acc) begin
                overflow_next = 1'b1;
            end
            if (io_pop && !pop_acc) begin
                underflow_next = 1'b1;
            end
        end
    end

    // State registers; reset clears immediately, independent of the clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_reg[AW-1:0]),
        .wdata (io_din),
        .raddr (rd_ptr_reg[AW-1:0]),
        .rdata (io_dout)
    );

    assign io_empty        = empty;
    assign io_full         = full;
    assign io_count        = count;
    assign io_almost_full  = (count >= AF_THR);
    assign io_almost_empty = (count <= AE_THR);
    assign io_overflow     = overflow_reg;
    assign io_underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_p.sv
// Directed plus randomized bench for sync_fifo_p, checked against a queue model.
module tb_sync_fifo_p;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 8;
    localparam int AF_LEVEL = 7;
    localparam int AE_LEVEL = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic              push = 1'b0;
    logic              pop = 1'b0;
    logic              flush = 1'b0;
    logic [DATA_W-1:0] dout;
    logic              empty, full, almost_full, almost_empty, overflow, underflow;
    logic [3:0]        count;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of stored words plus the two sticky flags.
    logic [DATA_W-1:0] q[$];
    bit                m_ovf = 1'b0;
    bit                m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_p #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk             (clk),
        .reset           (rst_n),
        .io_din          (din),
        .io_push         (push),
        .io_pop          (pop),
        .io_flush        (flush),
        .io_dout         (dout),
        .io_empty        (empty),
        .io_full         (full),
        .io_count        (count),
        .io_almost_full  (almost_full),
        .io_almost_empty (almost_empty),
        .io_overflow     (overflow),
        .io_underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_model(input string ctx);
        int sz;
        sz = q.size();
        chk({ctx, ".count"},     32'(count),        32'(sz));
        chk({ctx, ".empty"},     32'(empty),        32'(sz == 0));
        chk({ctx, ".full"},      32'(full),         32'(sz == DEPTH));
        chk({ctx, ".afull"},     32'(almost_full),  32'(sz >= AF_LEVEL));
        chk({ctx, ".aempty"},    32'(almost_empty), 32'(sz <= AE_LEVEL));
        chk({ctx, ".overflow"},  32'(overflow),     32'(m_ovf));
        chk({ctx, ".underflow"}, 32'(underflow),    32'(m_unf));
        if (sz > 0) begin
            chk({ctx, ".dout"}, 32'(dout), 32'(q[0]));
        end
    endtask

    // Literal reset values of every output.
    task automatic check_reset(input string ctx);
        chk({ctx, ".count"},     32'(count),        32'd0);
        chk({ctx, ".empty"},     32'(empty),        32'd1);
        chk({ctx, ".full"},      32'(full),         32'd0);
        chk({ctx, ".aempty"},    32'(almost_empty), 32'd1);
        chk({ctx, ".afull"},     32'(almost_full),  32'd0);
        chk({ctx, ".overflow"},  32'(overflow),     32'd0);
        chk({ctx, ".underflow"}, 32'(underflow),    32'd0);
    endtask

    // One clock of stimulus: drive, let the edge happen, update model, check.
    task automatic cycle(input bit psh, input bit pp, input bit fl, input logic [DATA_W-1:0] d);
        bit pop_ok;
        bit push_ok;
        push  = psh;
        pop   = pp;
        flush = fl;
        din   = d;
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            pop_ok  = pp && (q.size() > 0);
            push_ok = psh && ((q.size() < DEPTH) || pop_ok);
            if (pp && !pop_ok)   m_unf = 1'b1;
            if (psh && !push_ok) m_ovf = 1'b1;
            if (pop_ok)  void'(q.pop_front());
            if (push_ok) q.push_back(d);
        end
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        $display("t=%0t push=%0b pop=%0b flush=%0b din=%02h -> count=%0d dout=%02h",
                 $time, psh, pp, fl, d, count, dout);
        check_model("step");
    endtask

    initial begin
        int pbias;
        logic [DATA_W-1:0] seq;

        // Reset state.
        @(posedge clk);
        #1;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, overflow with 0xFF, drain in order.
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, 1'b0, DATA_W'(i));
            if (i == AF_LEVEL) chk("afull_at_7", 32'(almost_full), 32'd1);
        end
        cycle(1'b1, 1'b0, 1'b0, 8'hFF);
        chk("full_after_ff",  32'(full),     32'd1);
        chk("count_after_ff", 32'(count),    32'd8);
        chk("ovf_after_ff",   32'(overflow), 32'd1);
        for (int i = 1; i <= DEPTH; i++) begin
            chk("pop_order", 32'(dout), 32'(i));
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("drained_empty", 32'(empty), 32'd1);

        // Full with simultaneous push/pop across pointer wraps.
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, DATA_W'(8'h10 + i));
        seq = 8'h10;
        for (int i = 0; i < 20; i++) begin
            chk("wrap_order", 32'(dout), 32'(seq));
            cycle(1'b1, 1'b1, 1'b0, DATA_W'(8'h18 + i));
            seq = seq + 8'd1;
            chk("wrap_count", 32'(count), 32'd8);
        end
        for (int i = 0; i < DEPTH; i++) begin
            chk("wrap_drain", 32'(dout), 32'(seq));
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            seq = seq + 8'd1;
        end

        // Push with pop on an empty FIFO: pop rejected, no bypass.
        cycle(1'b1, 1'b1, 1'b0, 8'hA5);
        chk("nobypass_count", 32'(count),     32'd1);
        chk("nobypass_unf",   32'(underflow), 32'd1);
        chk("nobypass_dout",  32'(dout),      32'hA5);

        // Flush with push asserted at count 5, then a fresh push.
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, DATA_W'(8'h40 + i));
        chk("preflush_count", 32'(count), 32'd5);
        cycle(1'b1, 1'b0, 1'b1, 8'h77);
        chk("flush_count", 32'(count),     32'd0);
        chk("flush_empty", 32'(empty),     32'd1);
        chk("flush_ovf",   32'(overflow),  32'd0);
        chk("flush_unf",   32'(underflow), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'h3C);
        chk("post_flush_dout", 32'(dout), 32'h3C);

        // Asynchronous reset mid-stream at count 6.
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, DATA_W'(8'h60 + i));
        chk("prereset_count", 32'(count), 32'd6);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        check_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        check_model("after_reset");

        // Randomized traffic with drifting push bias to visit full and empty.
        for (int i = 0; i < 400; i++) begin
            pbias = ((i / 40) % 2 == 0) ? 75 : 25;
            cycle(($urandom_range(0, 99) < pbias),
                  ($urandom_range(0, 99) < (100 - pbias)),
                  ($urandom_range(0, 99) < 2),
                  DATA_W'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
